// File: rtl/branch_pattern_predictor_pkg.sv
// Shared definitions for the branch pattern predictor: mode encoding and default sizing.
// The optional per-entry tag check is enabled by defining BPP_TAG_CHECK_EN.
package branch_pattern_predictor_pkg;

  typedef enum logic {
    BPP_LEARN  = 1'b0,
    BPP_REPLAY = 1'b1
  } bpp_mode_e;

  localparam int BPP_DEF_ENTRY_NUM   = 256;
  localparam int BPP_DEF_HIST_LEN    = 10;
  localparam int BPP_DEF_MISS_THRESH = 2;
  localparam int BPP_DEF_TAG_WIDTH   = 8;

endpackage

// File: rtl/branch_pattern_predictor_if.sv
// Fetch/execute side bus of the branch pattern predictor.
// Tag signals exist only when BPP_TAG_CHECK_EN is defined.
interface branch_pattern_predictor_if #(
  parameter int ADDR_WIDTH = 8
`ifdef BPP_TAG_CHECK_EN
  , parameter int TAG_WIDTH = 8
`endif
);

  logic [ADDR_WIDTH-1:0] predictor_raddr;
  logic [ADDR_WIDTH-1:0] predictor_waddr;
  logic                  predictor_wen;
  logic                  branch_taken_ex;
  logic                  predictor_flush;
  logic                  predictor_rd_data;
  logic                  predictor_rd_replay;
`ifdef BPP_TAG_CHECK_EN
  logic [TAG_WIDTH-1:0]  predictor_rtag;
  logic [TAG_WIDTH-1:0]  predictor_wtag;

  modport master (
    output predictor_raddr, predictor_waddr, predictor_wen, branch_taken_ex,
           predictor_flush, predictor_rtag, predictor_wtag,
    input  predictor_rd_data, predictor_rd_replay
  );

  modport slave (
    input  predictor_raddr, predictor_waddr, predictor_wen, branch_taken_ex,
           predictor_flush, predictor_rtag, predictor_wtag,
    output predictor_rd_data, predictor_rd_replay
  );
`else
  modport master (
    output predictor_raddr, predictor_waddr, predictor_wen, branch_taken_ex,
           predictor_flush,
    input  predictor_rd_data, predictor_rd_replay
  );

  modport slave (
    input  predictor_raddr, predictor_waddr, predictor_wen, branch_taken_ex,
           predictor_flush,
    output predictor_rd_data, predictor_rd_replay
  );
`endif

endinterface

// File: rtl/branch_pattern_predictor_entry.sv
// One predictor entry: learns the first HIST_LEN outcomes, then replays them cyclically.
// With BPP_TAG_CHECK_EN defined the entry also holds a tag and reinitialises on tag change.
module bpp_entry
  import branch_pattern_predictor_pkg::*;
#(
  parameter int HIST_LEN    = BPP_DEF_HIST_LEN,
  parameter int MISS_THRESH = BPP_DEF_MISS_THRESH
`ifdef BPP_TAG_CHECK_EN
  , parameter int TAG_WIDTH = BPP_DEF_TAG_WIDTH
`endif
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 flush,
  input  logic                 wen,
  input  logic                 taken,
`ifdef BPP_TAG_CHECK_EN
  input  logic [TAG_WIDTH-1:0] wtag,
  output logic [TAG_WIDTH-1:0] tag,
`endif
  output logic                 pred,
  output logic                 replay
);

  localparam int FILL_W = $clog2(HIST_LEN + 1);
  localparam int PTR_W  = $clog2(HIST_LEN);
  localparam int MISS_W = $clog2(MISS_THRESH + 1);

  bpp_mode_e            mode_q, mode_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [HIST_LEN-1:0]  hist_q, hist_d;
  logic [PTR_W-1:0]     ptr_q,  ptr_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
`ifdef BPP_TAG_CHECK_EN
  logic [TAG_WIDTH-1:0] tag_q,  tag_d;

  assign tag = tag_q;
`endif

  // Most recently learned outcome; 0 while nothing has been learned yet.
  logic last;
  always_comb begin
    last = 1'b0;
    for (int i = 0; i < HIST_LEN; i++) begin
      if (fill_q == FILL_W'(i + 1)) last = hist_q[i];
    end
  end

  assign replay = (mode_q == BPP_REPLAY);
  assign pred   = replay ? hist_q[ptr_q] : last;

  // NOTE: every output of this block is given its hold value first, so no path leaves a latch.
  always_comb begin
    mode_d = mode_q;
    fill_d = fill_q;
    hist_d = hist_q;
    ptr_d  = ptr_q;
    miss_d = miss_q;
`ifdef BPP_TAG_CHECK_EN
    tag_d  = tag_q;
`endif
    if (wen) begin
`ifdef BPP_TAG_CHECK_EN
      if (tag_q != wtag) begin
        tag_d     = wtag;
        mode_d    = BPP_LEARN;
        hist_d[0] = taken;
        fill_d    = FILL_W'(1);
        ptr_d     = '0;
        miss_d    = '0;
      end else
`endif
      if (mode_q == BPP_LEARN) begin
        for (int i = 0; i < HIST_LEN; i++) begin
          if (fill_q == FILL_W'(i)) hist_d[i] = taken;
        end
        fill_d = fill_q + 1'b1;
        if (fill_q == FILL_W'(HIST_LEN - 1)) begin
          mode_d = BPP_REPLAY;
          ptr_d  = '0;
          miss_d = '0;
        end
      end else begin
        ptr_d = (ptr_q == PTR_W'(HIST_LEN - 1)) ? '0 : ptr_q + 1'b1;
        if (taken == hist_q[ptr_q]) begin
          miss_d = '0;
        end else if (miss_q + 1'b1 == MISS_W'(MISS_THRESH)) begin
          // Pattern no longer holds: start learning afresh.
          mode_d = BPP_LEARN;
          fill_d = '0;
          ptr_d  = '0;
          miss_d = '0;
        end else begin
          miss_d = miss_q + 1'b1;
        end
      end
    end
  end

  // NOTE: entry state lives in flops rather than a RAM because reset and flush must clear
  // every entry at once; non-blocking assignments keep all entries updating in lockstep.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      mode_q <= BPP_LEARN;
      fill_q <= '0;
      hist_q <= '0;
      ptr_q  <= '0;
      miss_q <= '0;
`ifdef BPP_TAG_CHECK_EN
      tag_q  <= '0;
`endif
    end else if (flush) begin
      mode_q <= BPP_LEARN;
      fill_q <= '0;
      hist_q <= '0;
      ptr_q  <= '0;
      miss_q <= '0;
`ifdef BPP_TAG_CHECK_EN
      tag_q  <= '0;
`endif
    end else begin
      mode_q <= mode_d;
      fill_q <= fill_d;
      hist_q <= hist_d;
      ptr_q  <= ptr_d;
      miss_q <= miss_d;
`ifdef BPP_TAG_CHECK_EN
      tag_q  <= tag_d;
`endif
    end
  end

endmodule

// File: rtl/branch_pattern_predictor.sv
// Per-entry pattern branch predictor: ENTRY_NUM bpp_entry instances, read mux, registered outputs.
// Define BPP_TAG_CHECK_EN to add per-entry tags that gate reads and reinitialise on writes.
module branch_pattern_predictor
  import branch_pattern_predictor_pkg::*;
#(
  parameter int ENTRY_NUM   = BPP_DEF_ENTRY_NUM,
  parameter int ADDR_WIDTH  = $clog2(ENTRY_NUM),
  parameter int HIST_LEN    = BPP_DEF_HIST_LEN,
  parameter int MISS_THRESH = BPP_DEF_MISS_THRESH,
  parameter int TAG_WIDTH   = BPP_DEF_TAG_WIDTH
) (
  input logic                       cpu_clk,
  input logic                       cpu_rstn,
  branch_pattern_predictor_if.slave bus
);

  if (HIST_LEN < 2 || MISS_THRESH < 1 || TAG_WIDTH < 1 ||
      (1 << ADDR_WIDTH) != ENTRY_NUM) begin : g_bad_param
    $error("branch_pattern_predictor: illegal parameter combination");
  end

  logic [ENTRY_NUM-1:0] pred_vec;
  logic [ENTRY_NUM-1:0] replay_vec;
`ifdef BPP_TAG_CHECK_EN
  logic [TAG_WIDTH-1:0] tag_vec [ENTRY_NUM];
`endif

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
    bpp_entry #(
      .HIST_LEN    (HIST_LEN),
      .MISS_THRESH (MISS_THRESH)
`ifdef BPP_TAG_CHECK_EN
      , .TAG_WIDTH (TAG_WIDTH)
`endif
    ) u_entry (
      .cpu_clk  (cpu_clk),
      .cpu_rstn (cpu_rstn),
      .flush    (bus.predictor_flush),
      .wen      (bus.predictor_wen && (bus.predictor_waddr == ADDR_WIDTH'(i))),
      .taken    (bus.branch_taken_ex),
`ifdef BPP_TAG_CHECK_EN
      .wtag     (bus.predictor_wtag),
      .tag      (tag_vec[i]),
`endif
      .pred     (pred_vec[i]),
      .replay   (replay_vec[i])
    );
  end

  // A stale tag makes the entry look untrained to fetch.
  logic hit;
`ifdef BPP_TAG_CHECK_EN
  assign hit = (tag_vec[bus.predictor_raddr] == bus.predictor_rtag);
`else
  assign hit = 1'b1;
`endif

  // Sampled from pre-update entry state, so same-cycle writes and flushes are not visible.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      bus.predictor_rd_data   <= 1'b0;
      bus.predictor_rd_replay <= 1'b0;
    end else begin
      bus.predictor_rd_data   <= hit & pred_vec[bus.predictor_raddr];
      bus.predictor_rd_replay <= hit & replay_vec[bus.predictor_raddr];
    end
  end

endmodule

// File: tb/tb_branch_pattern_predictor.sv
// Directed bench for branch_pattern_predictor (HIST_LEN=4, MISS_THRESH=2, 16 entries).
// Tag-check vectors are included when BPP_TAG_CHECK_EN is defined.
module tb_branch_pattern_predictor;

  localparam int ENTRY_NUM = 16;
  localparam int AW        = 4;
  localparam int HL        = 4;
  localparam int MT        = 2;
  localparam int TW        = 8;

  logic cpu_clk = 1'b0;
  logic cpu_rstn;

  branch_pattern_predictor_if #(
    .ADDR_WIDTH (AW)
`ifdef BPP_TAG_CHECK_EN
    , .TAG_WIDTH (TW)
`endif
  ) bus ();

  branch_pattern_predictor #(
    .ENTRY_NUM   (ENTRY_NUM),
    .ADDR_WIDTH  (AW),
    .HIST_LEN    (HL),
    .MISS_THRESH (MT),
    .TAG_WIDTH   (TW)
  ) u_dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic write(input int idx, input logic t);
    bus.predictor_waddr = AW'(idx);
    bus.branch_taken_ex = t;
    bus.predictor_wen   = 1'b1;
    tick();
    bus.predictor_wen   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic exp_d, input logic exp_r);
    bus.predictor_raddr = AW'(idx);
    tick();
    check({tag, "_data"},   32'(bus.predictor_rd_data),   32'(exp_d));
    check({tag, "_replay"}, 32'(bus.predictor_rd_replay), 32'(exp_r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pat [4];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1};

    cpu_rstn            = 1'b0;
    bus.predictor_raddr = '0;
    bus.predictor_waddr = '0;
    bus.predictor_wen   = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.predictor_flush = 1'b0;
`ifdef BPP_TAG_CHECK_EN
    bus.predictor_rtag  = '0;
    bus.predictor_wtag  = '0;
`endif
    #12;
    check("rst_data",   32'(bus.predictor_rd_data),   32'd0);
    check("rst_replay", 32'(bus.predictor_rd_replay), 32'd0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    read_chk("rd5_after_rst", 5, 1'b0, 1'b0);

    // Learn T,T,N,T on idx 3, then replay with matching outcomes.
    write(3, 1'b1);
    read_chk("learn_fill1", 3, 1'b1, 1'b0);
    write(3, 1'b1);
    write(3, 1'b0);
    read_chk("learn_fill3", 3, 1'b0, 1'b0);
    write(3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      read_chk($sformatf("replay_p%0d", k), 3, pat[k], 1'b1);
      write(3, pat[k]);
    end
    read_chk("replay_wrap", 3, 1'b1, 1'b1);

    // Two consecutive mispredicts on idx 4 (pattern 1,0,1,0) force relearn.
    write(4, 1'b1); write(4, 1'b0); write(4, 1'b1); write(4, 1'b0);
    read_chk("miss_pre", 4, 1'b1, 1'b1);
    write(4, 1'b0);
    write(4, 1'b1);
    read_chk("miss_relearn", 4, 1'b0, 1'b0);
    write(4, 1'b1);
    read_chk("relearn_fill1", 4, 1'b1, 1'b0);
    write(4, 1'b0); write(4, 1'b0); write(4, 1'b1);
    read_chk("relearn_replay", 4, 1'b1, 1'b1);

    // Single mispredict then match on idx 6: miss clears, entry stays in REPLAY.
    write(6, 1'b1); write(6, 1'b0); write(6, 1'b1); write(6, 1'b0);
    write(6, 1'b0);
    read_chk("one_miss", 6, 1'b0, 1'b1);
    write(6, 1'b0);
    write(6, 1'b0);
    read_chk("miss_cleared", 6, 1'b0, 1'b1);

    // Same-cycle read and write on idx 7 returns the pre-update state.
    write(7, 1'b0); write(7, 1'b1);
    bus.predictor_raddr = AW'(7);
    bus.predictor_waddr = AW'(7);
    bus.branch_taken_ex = 1'b0;
    bus.predictor_wen   = 1'b1;
    tick();
    bus.predictor_wen   = 1'b0;
    check("rbw_data",   32'(bus.predictor_rd_data),   32'd1);
    check("rbw_replay", 32'(bus.predictor_rd_replay), 32'd0);
    read_chk("rbw_after", 7, 1'b0, 1'b0);

    // Flush with a concurrent write and read on idx 1.
    write(1, 1'b1); write(1, 1'b1); write(1, 1'b1); write(1, 1'b1);
    bus.predictor_raddr = AW'(1);
    bus.predictor_waddr = AW'(1);
    bus.branch_taken_ex = 1'b0;
    bus.predictor_wen   = 1'b1;
    bus.predictor_flush = 1'b1;
    tick();
    bus.predictor_wen   = 1'b0;
    bus.predictor_flush = 1'b0;
    check("flush_pre_data",   32'(bus.predictor_rd_data),   32'd1);
    check("flush_pre_replay", 32'(bus.predictor_rd_replay), 32'd1);
    read_chk("flush_idx1", 1, 1'b0, 1'b0);
    read_chk("flush_idx3", 3, 1'b0, 1'b0);
    write(1, 1'b1);
    read_chk("flush_relearn", 1, 1'b1, 1'b0);

    // Asynchronous reset mid-operation.
    write(9, 1'b1);
    read_chk("arst_pre", 9, 1'b1, 1'b0);
    #2;
    cpu_rstn = 1'b0;
    #1;
    check("arst_now_data", 32'(bus.predictor_rd_data), 32'd0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    read_chk("arst_idx9", 9, 1'b0, 1'b0);
    read_chk("arst_idx1", 1, 1'b0, 1'b0);

`ifdef BPP_TAG_CHECK_EN
    bus.predictor_wtag = 8'h12;
    write(10, 1'b1);
    write(10, 1'b1);
    bus.predictor_rtag = 8'h12;
    read_chk("tag_hit", 10, 1'b1, 1'b0);
    bus.predictor_rtag = 8'h34;
    read_chk("tag_miss", 10, 1'b0, 1'b0);
    bus.predictor_wtag = 8'h34;
    write(10, 1'b1);
    read_chk("tag_new", 10, 1'b1, 1'b0);
    bus.predictor_wtag = 8'h34;
    write(10, 1'b0);
    read_chk("tag_fill2", 10, 1'b0, 1'b0);
    bus.predictor_rtag = 8'h12;
    read_chk("tag_old", 10, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
